// File: rtl/dmac_pkg.sv
// Shared FSM state encoding and opmode bit positions for the burst DMA master.
package dmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_REQUEST = 3'd2,
    S_READ    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  localparam int OPM_SRC_INC = 0;
  localparam int OPM_DST_INC = 1;

endpackage

// File: rtl/dmac_burst_buf.sv
// Burst staging buffer: BURST words, filled in read order and drained in the same order.
// Zero-latency read of the word at the read pointer; clr rewinds both pointers for the next burst.
module dmac_burst_buf #(
  parameter int DATA_W = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int PW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [DATA_W-1:0] mem [BURST];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BURST; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (we) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (re) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dmac_burst_master.sv
// Descriptor-driven DMA master: pops descriptors, copies each in read-burst / write-burst chunks.
// Waits indefinitely for M_grant in REQUEST; grant loss mid-burst is a sticky error, op_clear aborts.
module dmac_burst_master
  import dmac_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 16,
  parameter int CNT_W  = 4,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [1:0]        opmode,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic [ADDR_W-1:0] ds_addr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [CNT_W-1:0]  data_count,
  output logic              rd_en,
  output logic              M_req,
  input  logic              M_grant,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din,
  output logic              op_done,
  output logic              err,
  output logic              busy,
  output logic [2:0]        state,
  output logic [SIZE_W-1:0] xfer_count
);

  localparam int CW = $clog2(BURST) + 1;

  state_t            st;
  state_t            nxt;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [SIZE_W-1:0] remaining;
  logic [1:0]        mode;
  logic [CW-1:0]     chunk;
  logic [CW-1:0]     chunk_c;
  logic [CW-1:0]     rd_idx;
  logic [CW-1:0]     wr_idx;
  logic              buf_clr;
  logic              buf_we;
  logic              buf_re;
  logic [DATA_W-1:0] buf_rdata;

  assign chunk_c = (remaining < SIZE_W'(BURST)) ? CW'(remaining) : CW'(BURST);

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:    if (!op_clear && op_start) nxt = (data_count != '0) ? S_POP : S_DONE;
      S_POP: begin
        if (op_clear)               nxt = S_IDLE;
        else if (data_size != '0)   nxt = S_REQUEST;
        else if (data_count != '0)  nxt = S_POP;
        else                        nxt = S_DONE;
      end
      S_REQUEST: begin
        if (op_clear)     nxt = S_IDLE;
        else if (M_grant) nxt = S_READ;
      end
      S_READ: begin
        if (op_clear)             nxt = S_IDLE;
        else if (!M_grant)        nxt = S_DONE;
        else if (rd_idx == chunk) nxt = S_WRITE;
      end
      S_WRITE: begin
        if (op_clear)                    nxt = S_IDLE;
        else if (!M_grant)               nxt = S_DONE;
        else if (wr_idx == chunk - 1'b1) nxt = S_GAP;
      end
      S_GAP: begin
        if (op_clear)              nxt = S_IDLE;
        else if (remaining != '0)  nxt = S_REQUEST;
        else if (data_count != '0) nxt = S_POP;
        else                       nxt = S_DONE;
      end
      S_DONE:    if (op_clear) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // The pop is issued one cycle ahead so the FIFO output is valid during POP.
  assign rd_en = reset_n && (nxt == S_POP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      M_req      <= 1'b0;
      M_wr       <= 1'b0;
      busy       <= 1'b0;
      op_done    <= 1'b0;
      err        <= 1'b0;
      xfer_count <= '0;
      src        <= '0;
      dst        <= '0;
      remaining  <= '0;
      mode       <= '0;
      chunk      <= '0;
      rd_idx     <= '0;
      wr_idx     <= '0;
    end else begin
      st      <= nxt;
      M_req   <= (nxt inside {S_REQUEST, S_READ, S_WRITE});
      M_wr    <= (nxt == S_WRITE);
      busy    <= !(nxt inside {S_IDLE, S_DONE});
      op_done <= (nxt == S_DONE);

      if (st == S_IDLE && nxt != S_IDLE) begin
        err        <= 1'b0;
        xfer_count <= '0;
      end
      if (st == S_DONE && nxt == S_IDLE) begin
        err        <= 1'b0;
        xfer_count <= '0;
      end
      if ((st == S_READ || st == S_WRITE) && !op_clear && !M_grant) err <= 1'b1;

      if (st == S_POP) begin
        src       <= sc_addr;
        dst       <= ds_addr;
        remaining <= data_size;
        mode      <= opmode;
      end
      if (st == S_REQUEST) begin
        chunk  <= chunk_c;
        rd_idx <= '0;
        wr_idx <= '0;
      end
      if (st == S_READ && rd_idx != chunk) begin
        src    <= src + ADDR_W'(mode[OPM_SRC_INC]);
        rd_idx <= rd_idx + 1'b1;
      end
      // A write only counts once the bus still holds grant for it.
      if (st == S_WRITE && M_grant) begin
        dst    <= dst + ADDR_W'(mode[OPM_DST_INC]);
        wr_idx <= wr_idx + 1'b1;
        if (xfer_count != '1) xfer_count <= xfer_count + 1'b1;
        if (nxt == S_GAP)     remaining  <= remaining - SIZE_W'(chunk);
      end
    end
  end

  // Read data trails its address by one cycle, so the first READ cycle stores nothing.
  assign buf_we  = (st == S_READ) && (rd_idx != '0);
  assign buf_re  = (st == S_WRITE);
  assign buf_clr = !(st == S_READ || st == S_WRITE);

  dmac_burst_buf #(
    .DATA_W (DATA_W),
    .BURST  (BURST)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (buf_clr),
    .we      (buf_we),
    .wdata   (M_din),
    .re      (buf_re),
    .rdata   (buf_rdata)
  );

  assign M_address = (st == S_READ) ? src : (st == S_WRITE) ? dst : '0;
  assign M_dout    = (st == S_WRITE) ? buf_rdata : '0;
  assign state     = st;

endmodule

// File: tb/tb_dmac_burst_master.sv
// Directed bench for dmac_burst_master with a descriptor FIFO model and a one-cycle-latency memory.
module tb_dmac_burst_master;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd2, ST_READ = 3'd3,
                         ST_WRITE = 3'd4, ST_DONE = 3'd5, ST_GAP = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n, op_start, op_clear, M_grant;
  logic [1:0]  opmode = '0;
  logic [7:0]  sc_addr = '0, ds_addr = '0;
  logic [15:0] data_size = '0;
  logic [3:0]  data_count;
  logic        rd_en, M_req, M_wr, op_done, err, busy;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic [31:0] M_din = '0;
  logic [2:0]  state;
  logic [15:0] xfer_count;

  dmac_burst_master dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .opmode(opmode), .sc_addr(sc_addr), .ds_addr(ds_addr), .data_size(data_size),
    .data_count(data_count), .rd_en(rd_en), .M_req(M_req), .M_grant(M_grant),
    .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout), .M_din(M_din),
    .op_done(op_done), .err(err), .busy(busy), .state(state), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  d_src [16];
  logic [7:0]  d_dst [16];
  logic [15:0] d_size [16];
  logic [1:0]  d_mode [16];
  int nq = 0;
  int hd = 0;
  assign data_count = 4'(nq - hd);

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  rd_log[$];
  int          runs[$];
  int run = 0, n_rd = 0, n_gap = 0, n_read = 0;
  logic [7:0] last_addr = '0;
  int b_wa, b_runs, b_rd, b_gap, b_read, b_rl;

  function automatic logic [31:0] mdat(input logic [7:0] a);
    mdat = {24'hC0DE00, a};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_en) n_rd++;
      if (state == ST_GAP) n_gap++;
      if (state == ST_READ) begin
        n_read++;
        rd_log.push_back(M_address);
      end
      if (M_wr) begin
        wa.push_back(M_address);
        wd.push_back(M_dout);
        run++;
      end else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
    last_addr = M_address;
  end

  // Memory returns the previous cycle's address; FIFO presents a popped entry the cycle after rd_en.
  int popped = 0;
  always begin
    @(posedge clk);
    #1;
    M_din = mdat(last_addr);
    if (n_rd > popped && hd < nq) begin
      sc_addr   = d_src[hd];
      ds_addr   = d_dst[hd];
      data_size = d_size[hd];
      opmode    = d_mode[hd];
      hd++;
      popped++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] d, input logic [15:0] n, input logic [1:0] m);
    d_src[nq] = s; d_dst[nq] = d; d_size[nq] = n; d_mode[nq] = m;
    nq++;
  endtask

  task automatic mark();
    b_wa = wa.size(); b_runs = runs.size(); b_rd = n_rd;
    b_gap = n_gap; b_read = n_read; b_rl = rd_log.size();
  endtask

  function automatic int nw();
    return wa.size() - b_wa;
  endfunction

  task automatic chk_wr(input string tag, input int i, input logic [7:0] a, input logic [31:0] d);
    if (b_wa + i < wa.size()) begin
      chk({tag, "_addr"}, wa[b_wa + i], a);
      chk({tag, "_data"}, wd[b_wa + i], d);
    end else chk({tag, "_count"}, nw(), i + 1);
  endtask

  task automatic chk_run(input string tag, input int k, input int exp);
    if (b_runs + k < runs.size()) chk(tag, runs[b_runs + k], exp);
    else chk(tag, 0, exp);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state !== s && n < 400) begin
      tick();
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic run_op(input string tag);
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    wait_state(ST_DONE, tag);
  endtask

  task automatic clear_done(input string tag);
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    chk({tag, "_clr_state"}, state, ST_IDLE);
    chk({tag, "_clr_done"}, op_done, 0);
    chk({tag, "_clr_err"}, err, 0);
    chk({tag, "_clr_xfer"}, xfer_count, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0; M_grant = 1'b1;
    repeat (3) tick();
    chk("rst_state", state, ST_IDLE);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_req", M_req, 0);
    chk("rst_wr", M_wr, 0);
    chk("rst_addr", M_address, 0);
    chk("rst_dout", M_dout, 0);
    chk("rst_done", op_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xfer", xfer_count, 0);
    #2 reset_n = 1'b1;
    tick();

    // start with an empty descriptor FIFO
    mark();
    run_op("t0_reach_done");
    chk("t0_err", err, 0);
    chk("t0_done", op_done, 1);
    chk("t0_rd_en", n_rd - b_rd, 0);
    chk("t0_busy", busy, 0);
    clear_done("t0");

    // single descriptor, two bursts (4 + 2)
    push(8'h10, 8'h80, 16'd6, 2'd3);
    mark();
    run_op("t1_reach_done");
    chk("t1_nwrites", nw(), 6);
    for (int i = 0; i < 6; i++) chk_wr("t1_w", i, 8'(8'h80 + i), mdat(8'(8'h10 + i)));
    chk("t1_nruns", runs.size() - b_runs, 2);
    chk_run("t1_run0", 0, 4);
    chk_run("t1_run1", 1, 2);
    chk("t1_gaps", n_gap - b_gap, 2);
    chk("t1_read_cycles", n_read - b_read, 8);
    chk("t1_rd_en", n_rd - b_rd, 1);
    chk("t1_done", op_done, 1);
    chk("t1_err", err, 0);
    chk("t1_xfer", xfer_count, 6);
    chk("t1_req", M_req, 0);
    chk("t1_busy", busy, 0);
    clear_done("t1");

    // fixed source, incrementing destination
    push(8'h20, 8'h40, 16'd3, 2'd2);
    mark();
    run_op("t2a_reach_done");
    chk("t2a_nwrites", nw(), 3);
    for (int i = 0; i < 3; i++) chk_wr("t2a_w", i, 8'(8'h40 + i), mdat(8'h20));
    chk("t2a_read_cycles", rd_log.size() - b_rl, 4);
    for (int k = b_rl; k < rd_log.size(); k++) chk("t2a_raddr", rd_log[k], 8'h20);
    clear_done("t2a");

    // incrementing source, fixed destination
    push(8'h20, 8'h40, 16'd3, 2'd1);
    mark();
    run_op("t2b_reach_done");
    chk("t2b_nwrites", nw(), 3);
    for (int i = 0; i < 3; i++) chk_wr("t2b_w", i, 8'h40, mdat(8'(8'h20 + i)));
    clear_done("t2b");

    // three descriptors with a zero-size one in the middle
    push(8'h00, 8'h90, 16'd2, 2'd3);
    push(8'h50, 8'h60, 16'd0, 2'd3);
    push(8'h30, 8'hA0, 16'd5, 2'd3);
    mark();
    run_op("t3_reach_done");
    chk("t3_rd_en", n_rd - b_rd, 3);
    chk("t3_nwrites", nw(), 7);
    chk_wr("t3_w0", 0, 8'h90, mdat(8'h00));
    chk_wr("t3_w1", 1, 8'h91, mdat(8'h01));
    for (int i = 0; i < 5; i++) chk_wr("t3_wb", 2 + i, 8'(8'hA0 + i), mdat(8'(8'h30 + i)));
    chk_run("t3_run0", 0, 2);
    chk_run("t3_run1", 1, 4);
    chk_run("t3_run2", 2, 1);
    chk("t3_gaps", n_gap - b_gap, 3);
    chk("t3_xfer", xfer_count, 7);
    chk("t3_fifo_empty", data_count, 0);
    clear_done("t3");

    // late grant, then grant lost on the second write
    M_grant = 1'b0;
    push(8'h08, 8'hC0, 16'd4, 2'd3);
    mark();
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    wait_state(ST_REQ, "t4_reach_req");
    repeat (5) begin
      chk("t4_req_hold", M_req, 1);
      chk("t4_req_state", state, ST_REQ);
      tick();
    end
    M_grant = 1'b1;
    wait_state(ST_WRITE, "t4_reach_write");
    tick();
    M_grant = 1'b0;
    tick();
    chk("t4_state", state, ST_DONE);
    chk("t4_err", err, 1);
    chk("t4_done", op_done, 1);
    chk("t4_req", M_req, 0);
    chk("t4_wr", M_wr, 0);
    repeat (4) tick();
    chk("t4_nwrites", nw(), 2);
    chk_wr("t4_w0", 0, 8'hC0, mdat(8'h08));
    chk_wr("t4_w1", 1, 8'hC1, mdat(8'h09));
    M_grant = 1'b1;
    clear_done("t4");

    // abort in the second READ cycle, then a normal run
    push(8'h00, 8'h70, 16'd4, 2'd3);
    mark();
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    wait_state(ST_READ, "t5_reach_read");
    tick();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    chk("t5_state", state, ST_IDLE);
    chk("t5_req", M_req, 0);
    chk("t5_wr", M_wr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", op_done, 0);
    repeat (3) tick();
    chk("t5_nwrites", nw(), 0);
    push(8'h00, 8'h70, 16'd4, 2'd3);
    mark();
    run_op("t5b_reach_done");
    chk("t5b_nwrites", nw(), 4);
    for (int i = 0; i < 4; i++) chk_wr("t5b_w", i, 8'(8'h70 + i), mdat(8'(i)));
    chk("t5b_xfer", xfer_count, 4);
    clear_done("t5b");

    // destination wraps past the top of the address space
    push(8'h05, 8'hFE, 16'd4, 2'd2);
    mark();
    run_op("t6_reach_done");
    chk("t6_nwrites", nw(), 4);
    for (int i = 0; i < 4; i++) chk_wr("t6_w", i, 8'(8'hFE + i), mdat(8'h05));
    clear_done("t6");

    // asynchronous reset in the middle of a write burst
    push(8'h05, 8'hFE, 16'd4, 2'd2);
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    wait_state(ST_WRITE, "t7_reach_write");
    tick();
    chk("t7_mid_write", M_wr, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_state", state, ST_IDLE);
    chk("t7_req", M_req, 0);
    chk("t7_wr", M_wr, 0);
    chk("t7_addr", M_address, 0);
    chk("t7_dout", M_dout, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", op_done, 0);
    chk("t7_err", err, 0);
    chk("t7_xfer", xfer_count, 0);
    chk("t7_rd_en", rd_en, 0);
    #3 reset_n = 1'b1;
    repeat (4) tick();
    chk("t7_stay_idle", state, ST_IDLE);
    chk("t7_stay_noreq", M_req, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
